lsu: RTL and testbench

//  Load/store unit for the single-cycle RV32I core; sits downstream of the ALU and upstream of the register-file write port.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu.sv | 135 +++++++++++++
 tb/tb_lsu.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the RV32I load/store path.
// FSM states, access sizes and funct3 load/store codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } mem_size_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Codes 3, 6 and 7 are not legal sizes; they fall to word.
  function automatic mem_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU (combinational).
// Ports: lane/size/sext, st_data/rdata in; be, wdata, ld_data out.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [1:0]  lane,
  input  mem_size_t   size,
  input  logic        sext,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    be      = 4'b1111;
    wdata   = st_data;
    ld_data = rdata;
    b       = rdata[{lane, 3'b000} +: 8];
    h       = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B: begin
        be      = 4'b0001 << lane;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sext & b[7]}}, b};
      end
      SZ_H: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{sext & h[15]}}, h};
      end
      default: begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/gnt/rvalid transaction per access.
// Ports: clk, rst (sync, active-low), op inputs, stall/ld_*/err
// outputs, mem_* bus. Option macro: LSU_MISALIGN_TRAP_EN.
module lsu
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_load,
  input  logic              is_s_instr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       st_data,
  output logic              stall,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              bus_err,
  output logic              misalign_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CW =
    (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam int unsigned TLIM =
    (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wd_q;
  logic              we_q;
  logic [31:0]       ld_q;
  logic              ok_q, berr_q, mis_q;
  logic [CW-1:0]     cnt_q;

  logic        start, tmo, mis, in_req;
  logic [3:0]  be_w;
  logic [31:0] wdata_w, ext_w;

  assign start  = is_load | is_s_instr;
  assign in_req = (state_q == REQ);
  assign tmo    = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TLIM));

`ifdef LSU_MISALIGN_TRAP_EN
  mem_size_t sz_in;
  assign sz_in = f3_size(funct3);
  assign mis   = ((sz_in == SZ_H) & addr[0])
               | ((sz_in == SZ_W) & (|addr[1:0]));
`else
  assign mis = 1'b0;
`endif

  lsu_align u_align (
    .lane    (addr_q[1:0]),
    .size    (f3_size(f3_q)),
    .sext    (~f3_q[2]),
    .st_data (wd_q),
    .rdata   (mem_rdata),
    .be      (be_w),
    .wdata   (wdata_w),
    .ld_data (ext_w)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // The handshake wins over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = mis ? DONE : REQ;
      REQ: begin
        if (mem_gnt)  state_d = we_q ? DONE : WAIT;
        else if (tmo) state_d = DONE;
      end
      WAIT: if (mem_rvalid || tmo) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      f3_q   <= '0;
      wd_q   <= '0;
      we_q   <= 1'b0;
      ld_q   <= '0;
      ok_q   <= 1'b0;
      berr_q <= 1'b0;
      mis_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ok_q   <= (state_q == WAIT) && mem_rvalid;
      berr_q <= tmo && ((in_req && !mem_gnt) ||
                ((state_q == WAIT) && !mem_rvalid));
      mis_q  <= (state_q == IDLE) && start && mis;
      if (state_q == IDLE && start) begin
        addr_q <= addr;
        f3_q   <= funct3;
        wd_q   <= st_data;
        we_q   <= ~is_load;
        cnt_q  <= '0;
      end else if (in_req || state_q == WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == WAIT && mem_rvalid) ld_q <= ext_w;
    end
  end

  assign stall = ((state_q == IDLE) && start)
               | in_req | (state_q == WAIT);
  assign ld_valid     = ok_q;
  assign ld_data      = ld_q;
  assign bus_err      = berr_q;
  assign misalign_err = mis_q;
  assign mem_req      = in_req;
  assign mem_we       = in_req & we_q;
  assign mem_addr     =
    in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be       = in_req ? be_w : 4'b0000;
  assign mem_wdata    = in_req ? wdata_w : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: queued expectations, negedge monitor.
// Second instance with TIMEOUT_CYC=4 covers the abort path.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_load, is_s_instr;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        stall, ld_valid, bus_err, misalign_err;
  logic        mem_req, mem_we;
  logic [31:0] ld_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        stall_t, ld_valid_t, bus_err_t, mis_t;
  logic        req_t_o, we_t_o;
  logic [31:0] ld_data_t, addr_t_o, wdata_t_o;
  logic [3:0]  be_t_o;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .is_load(is_load),
    .is_s_instr(is_s_instr), .funct3(funct3), .addr(addr),
    .st_data(st_data), .stall(stall), .ld_valid(ld_valid),
    .ld_data(ld_data), .bus_err(bus_err),
    .misalign_err(misalign_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu #(.TIMEOUT_CYC(4)) dut_t (
    .clk(clk), .rst(rst), .is_load(is_load),
    .is_s_instr(is_s_instr), .funct3(funct3), .addr(addr),
    .st_data(st_data), .stall(stall_t), .ld_valid(ld_valid_t),
    .ld_data(ld_data_t), .bus_err(bus_err_t),
    .misalign_err(mis_t), .mem_req(req_t_o),
    .mem_we(we_t_o), .mem_addr(addr_t_o), .mem_be(be_t_o),
    .mem_wdata(wdata_t_o), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        rq[$];
  logic [31:0] lq[$];
  int          checks = 0;
  int          errors = 0;
  bit          mis_seen = 0;

  // memory model, driven from the main instance's bus
  bit          gnt_en = 1;
  int          gnt_dly = 0, rv_dly = 1;
  int          wait_cnt = 0, resp_cnt = 0, req_seen = 0;
  logic [31:0] rd_word = 32'h0;

  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_word;
      end
    end
    if (mem_req) begin
      req_seen++;
      if (gnt_en && wait_cnt >= gnt_dly) begin
        mem_gnt  = 1'b1;
        wait_cnt = 0;
        if (!mem_we) resp_cnt = rv_dly;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // monitor: pops expectations whenever the DUT presents output
  always @(negedge clk) begin
    req_t e;
    logic [31:0] x;
    #3;
    if (mem_req && mem_gnt) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got addr %h we %b want none",
                 mem_addr, mem_we);
      end else begin
        e = rq.pop_front();
        if (mem_we !== e.we || mem_addr !== e.addr ||
            (e.we && (mem_be !== e.be || mem_wdata !== e.wdata))) begin
          errors++;
          $display("FAIL req: got we%b %h be%b %h want we%b %h be%b %h",
                   mem_we, mem_addr, mem_be, mem_wdata,
                   e.we, e.addr, e.be, e.wdata);
        end
      end
    end
    if (ld_valid) begin
      checks++;
      if (lq.size() == 0) begin
        errors++;
        $display("FAIL ld_unexpected: got %h want no ld_valid",
                 ld_data);
      end else begin
        x = lq.pop_front();
        if (ld_data !== x) begin
          errors++;
          $display("FAIL ld_data: got %h want %h", ld_data, x);
        end
      end
    end
    if (misalign_err) mis_seen = 1;
  end

  task automatic chk(input logic [31:0] act, input logic [31:0] exp,
                     input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_st,
                        input string nm);
    int n;
    @(negedge clk);
    is_load = ld; is_s_instr = st;
    funct3 = f3; addr = a; st_data = wd;
    n = 0;
    #2;
    while (stall && n < 64) begin
      n++;
      @(negedge clk);
      is_load = 1'b0; is_s_instr = 1'b0;
      #2;
    end
    is_load = 1'b0; is_s_instr = 1'b0;
    chk(32'(n), 32'(exp_st), {nm, "_stall"});
  endtask

  task automatic ld_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] rd, input logic [31:0] exp,
                       input int exp_st, input string nm);
    rd_word = rd;
    rq.push_back('{1'b0, {a[31:2], 2'b00}, 4'b0000, 32'h0});
    lq.push_back(exp);
    run_op(1'b1, 1'b0, f3, a, 32'h0, exp_st, nm);
  endtask

  task automatic st_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] wdata, input string nm);
    rq.push_back('{1'b1, {a[31:2], 2'b00}, be, wdata});
    run_op(1'b0, 1'b1, f3, a, wd, 2, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b0;
    is_load = 1'b0; is_s_instr = 1'b0;
    funct3 = 3'd0; addr = 32'h0; st_data = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    chk(32'({stall, ld_valid, bus_err, misalign_err,
             mem_req, mem_we}), 32'h0, "rst_flags");
    chk(ld_data, 32'h0, "rst_ld_data");
    chk(mem_addr | mem_wdata | 32'(mem_be), 32'h0, "rst_bus");
    rst = 1'b1;

    ld_op(3'd0, 32'h103, 32'h80FF1234, 32'hFFFFFF80, 3, "lb103");
    ld_op(3'd4, 32'h103, 32'h80FF1234, 32'h00000080, 3, "lbu103");
    ld_op(3'd1, 32'h102, 32'h80FF1234, 32'hFFFF80FF, 3, "lh102");
    ld_op(3'd5, 32'h102, 32'h80FF1234, 32'h000080FF, 3, "lhu102");
    ld_op(3'd0, 32'h101, 32'h80FF1234, 32'h00000012, 3, "lb101");
    ld_op(3'd0, 32'h102, 32'h80FF1234, 32'hFFFFFFFF, 3, "lb102");
    ld_op(3'd3, 32'h200, 32'h80FF1234, 32'h80FF1234, 3, "f3_3");

    gnt_dly = 2; rv_dly = 2;
    ld_op(3'd2, 32'h200, 32'h12345678, 32'h12345678, 6, "lw_slow");
    gnt_dly = 0; rv_dly = 1;

    st_op(3'd1, 32'h102, 32'h0000ABCD, 4'b1100, 32'hABCDABCD, "sh102");
    st_op(3'd0, 32'h101, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, "sb101");
    st_op(3'd2, 32'h207, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, "sw207");
    st_op(3'd0, 32'h003, 32'h123456C3, 4'b1000, 32'hC3C3C3C3, "sb003");
    st_op(3'd1, 32'h100, 32'hFFFF1357, 4'b0011, 32'h13571357, "sh100");
    st_op(3'd7, 32'h10C, 32'h01020304, 4'b1111, 32'h01020304, "f3_7");

    // both op flags: the load is taken
    rd_word = 32'h55AA33CC;
    rq.push_back('{1'b0, 32'h400, 4'b0000, 32'h0});
    lq.push_back(32'h55AA33CC);
    run_op(1'b1, 1'b1, 3'd2, 32'h400, 32'h11111111, 3, "both");

    // reset while waiting for rvalid; rvalid then arrives late
    rv_dly = 4; rd_word = 32'hCAFEF00D;
    rq.push_back('{1'b0, 32'h500, 4'b0000, 32'h0});
    @(negedge clk);
    is_load = 1'b1; funct3 = 3'd2; addr = 32'h500;
    @(negedge clk);
    is_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk(32'({stall, ld_valid, bus_err, mem_req, mem_we}),
        32'h0, "midrst_flags");
    chk(ld_data, 32'h0, "midrst_ld_data");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    chk(ld_data, 32'h0, "late_rvalid_ld_data");
    rv_dly = 1;
    st_op(3'd2, 32'h600, 32'h0BADF00D, 4'b1111, 32'h0BADF00D, "sw_after");

    // timeout on the TIMEOUT_CYC=4 instance
    ld_op(3'd4, 32'h103, 32'h80FF1234, 32'h00000080, 3, "lbu_pre");
    gnt_en = 0;
    @(negedge clk);
    is_load = 1'b1; funct3 = 3'd2; addr = 32'h300;
    n0 = 0;
    #2;
    while (stall_t && n0 < 64) begin
      n0++;
      @(negedge clk);
      is_load = 1'b0;
      #2;
    end
    is_load = 1'b0;
    chk(32'(n0), 32'd5, "tmo_stall");
    chk(32'({bus_err_t, ld_valid_t}), 32'h2, "tmo_bus_err");
    chk(ld_data_t, 32'h00000080, "tmo_ld_data");
    @(negedge clk);
    #2;
    chk(32'(bus_err_t), 32'h0, "tmo_pulse");
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; gnt_en = 1;

`ifdef LSU_MISALIGN_TRAP_EN
    n0 = req_seen;
    @(negedge clk);
    is_load = 1'b1; funct3 = 3'd2; addr = 32'h101;
    #2;
    chk(32'(stall), 32'h1, "mis_stall");
    @(negedge clk);
    is_load = 1'b0;
    #2;
    chk(32'({stall, misalign_err, ld_valid}), 32'h2, "mis_done");
    @(negedge clk);
    #2;
    chk(32'(misalign_err), 32'h0, "mis_pulse");
    chk(32'(req_seen - n0), 32'h0, "mis_no_req");
    ld_op(3'd2, 32'h104, 32'h87654321, 32'h87654321, 3, "lw_align");
`else
    ld_op(3'd1, 32'h101, 32'h80FF1234, 32'h00001234, 3, "lh101");
    ld_op(3'd2, 32'h103, 32'h80FF1234, 32'h80FF1234, 3, "lw103");
    chk(32'(mis_seen), 32'h0, "no_misalign");
`endif

    repeat (3) @(negedge clk);
    #4;
    chk(32'(rq.size()), 32'h0, "req_queue_drained");
    chk(32'(lq.size()), 32'h0, "ld_queue_drained");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
